// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock for the 5-stage DLX core: turns hazard sources into
// per-boundary hold/clear controls, sequences multi-cycle mul/div occupancy.
module pipe_hazard_ctrl #(
  parameter int REG_BITS   = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                ex_load,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                branch_taken,
  input  logic                md_start,
  input  logic                md_div,
  input  logic                mem_wait,
  output logic                stall_if,
  output logic                stall_id,
  output logic                stall_ex,
  output logic                stall_mem,
  output logic                flush_id,
  output logic                flush_ex,
  output logic                flush_mem,
  output logic                md_done,
  output logic                proto_err,
  output logic [15:0]         stall_count
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             md_stall;
  logic             md_last;
  logic             load_use;

  assign md_last  = (state == MD_BUSY) && (cnt == CNT_ONE);
  assign md_stall = ((state == RUN) && md_start) || ((state == MD_BUSY) && (cnt > CNT_ONE));
  assign load_use = ex_load && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    md_done   = 1'b0;
    if (!reset_n) begin
      // Bubble the whole pipe while reset is held
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
    end else if (mem_wait) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (md_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      flush_mem = 1'b1;
    end else begin
      md_done = md_last;
      if (branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  // Whole FSM freezes while the data cache holds MEM (and thus EX)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else if (!mem_wait) begin
      case (state)
        RUN: begin
          if (md_start) begin
            cnt   <= md_div ? DIV_LOAD : MUL_LOAD;
            state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (md_start) proto_err <= 1'b1;
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              stall_count <= '0;
    else if (stall_if && (stall_count != '1))  stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors go through a
// scoreboard queue; stall_count/proto_err follow a small reference model.
module tb_pipe_hazard_ctrl;

  localparam int REG_BITS = 5;

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, md_done}
  localparam logic [7:0] NONE = 8'h00;
  localparam logic [7:0] RST  = 8'h0e;
  localparam logic [7:0] LU   = 8'hc4;
  localparam logic [7:0] MD   = 8'he2;
  localparam logic [7:0] WAIT = 8'hf0;
  localparam logic [7:0] BR   = 8'h0c;
  localparam logic [7:0] DONE = 8'h01;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [REG_BITS-1:0] id_rs, id_rt, ex_rd;
  logic                id_use_rs, id_use_rt, ex_load;
  logic                branch_taken, md_start, md_div, mem_wait;
  logic                stall_if, stall_id, stall_ex, stall_mem;
  logic                flush_id, flush_ex, flush_mem, md_done, proto_err;
  logic [15:0]         stall_count;
  logic [7:0]          outs;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_perr = 1'b0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, md_done};

  pipe_hazard_ctrl #(.REG_BITS(REG_BITS), .MUL_CYCLES(4), .DIV_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_load(ex_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .md_start(md_start), .md_div(md_div), .mem_wait(mem_wait),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .md_done(md_done), .proto_err(proto_err), .stall_count(stall_count)
  );

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_load = 0;
    branch_taken = 0; md_start = 0; md_div = 0; mem_wait = 0;
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    sb.push_back(exp);
    #1;
    e = sb.pop_front();
    tests++;
    assert (outs === e) else begin
      fails++; $error("FAIL %s: outs=%h expected=%h", tag, outs, e);
    end
    @(posedge clk);
    if (e[7] && exp_cnt != 16'hFFFF) exp_cnt++;
    #1;
    tests++;
    assert (stall_count === exp_cnt) else begin
      fails++; $error("FAIL %s_cnt: stall_count=%0d expected=%0d", tag, stall_count, exp_cnt);
    end
    tests++;
    assert (proto_err === exp_perr) else begin
      fails++; $error("FAIL %s_perr: proto_err=%b expected=%b", tag, proto_err, exp_perr);
    end
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    #2;
    chk("reset", RST);
    reset_n = 1'b1;
    chk("idle", NONE);

    // Load-use: one bubble, then clears
    ex_load = 1; ex_rd = 7; id_rs = 7; id_use_rs = 1;
    chk("lu_rs", LU);
    clr();
    chk("lu_after", NONE);
    ex_load = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    chk("lu_rd0", NONE);
    ex_load = 1; ex_rd = 12; id_rt = 12; id_use_rt = 1; id_rs = 3; id_use_rs = 1;
    chk("lu_rt", LU);
    ex_load = 1; ex_rd = 9; id_rs = 9; id_use_rs = 0;
    chk("lu_unused", NONE);
    ex_load = 0; ex_rd = 9; id_rs = 9; id_use_rs = 1;
    chk("lu_noload", NONE);
    clr();

    // Multiply: 3 stalled cycles, done in cycle 3; branch during md stall ignored
    md_start = 1; md_div = 0;
    chk("mul_c0", MD);
    clr(); branch_taken = 1;
    chk("mul_c1_br", MD);
    clr();
    chk("mul_c2", MD);
    chk("mul_c3", DONE);
    chk("mul_after", NONE);

    // Divide with a 3-cycle cache wait at cnt=8; branch in the done cycle applies
    md_start = 1; md_div = 1;
    chk("div_c0", MD);
    clr();
    for (int i = 0; i < 7; i++) chk("div_pre", MD);
    mem_wait = 1; md_start = 1;
    for (int i = 0; i < 3; i++) chk("div_wait", WAIT);
    clr();
    for (int i = 0; i < 7; i++) chk("div_post", MD);
    branch_taken = 1;
    chk("div_done_br", DONE | BR);
    clr();
    chk("div_after", NONE);

    // Branch beats load-use; branch deferred by mem_wait
    branch_taken = 1; ex_load = 1; ex_rd = 4; id_rs = 4; id_use_rs = 1;
    chk("br_lu", BR);
    clr(); branch_taken = 1; mem_wait = 1;
    chk("br_wait", WAIT);
    mem_wait = 0;
    chk("br_after_wait", BR);
    clr();

    // md_start while busy: sticky proto_err, timing unchanged
    md_start = 1;
    chk("perr_c0", MD);
    exp_perr = 1'b1;
    chk("perr_c1", MD);
    clr();
    chk("perr_c2", MD);
    chk("perr_c3", DONE);
    chk("perr_hold", NONE);

    // Saturation of stall_count under a long cache wait
    mem_wait = 1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      if (exp_cnt != 16'hFFFF) exp_cnt++;
      @(negedge clk);
    end
    tests++;
    assert (stall_count === 16'hFFFF) else begin
      fails++; $error("FAIL sat: stall_count=%h expected=ffff", stall_count);
    end
    chk("sat_hold", WAIT);
    clr();

    // Reset mid-divide at cnt=5
    md_start = 1; md_div = 1;
    chk("rdiv_c0", MD);
    clr();
    for (int i = 0; i < 10; i++) chk("rdiv_run", MD);
    reset_n = 1'b0;
    exp_cnt = '0; exp_perr = 1'b0;
    chk("rst_mid", RST);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) chk("post_rst", NONE);
    ex_load = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
    chk("post_rst_lu", LU);
    clr();
    chk("final", NONE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central interlock unit that drives the stall and flush lines of every stage-boundary pipeline register in the 5-stage DLX core (IF/ID, ID/EX, EX/MEM, MEM/WB). It consumes hazard sources and produces the per-stage hold and clear controls:
- load-use dependency
- taken branch resolved in EX
- multi-cycle multiply/divide in EX
- data-cache wait in MEM

Each pipeline register receives a stall (hold) line and a flush line, which clears the register to a bubble. Flush has priority over stall at each register.

Parameters:
REG_BITS, 5, register-specifier width
MUL_CYCLES, 4, cycles a multiply occupies EX (>=2)
DIV_CYCLES, 16, cycles a divide occupies EX (>=2)
CNT_W, 5, multi-cycle counter width (2^CNT_W > max(MUL_CYCLES, DIV_CYCLES))

Ports:
clk  in  1  core clock, all state on posedge
reset_n  in  1  asynchronous, active-low reset
id_rs  in  REG_BITS  source reg 1 of instruction in ID
id_rt  in  REG_BITS  source reg 2 of instruction in ID
id_use_rs  in  1  ID instruction reads id_rs
id_use_rt  in  1  ID instruction reads id_rt
ex_load  in  1  EX instruction is a load
ex_rd  in  REG_BITS  destination of EX instruction
branch_taken  in  1  EX resolved a taken branch/jump
md_start  in  1  EX instruction is mul/div, first EX cycle
md_div  in  1  qualifies md_start: 1 = divide, 0 = multiply
mem_wait  in  1  MEM stage waiting on data cache
stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold IF/ID, ID/EX, EX/MEM, MEM/WB register
flush_id, flush_ex, flush_mem  out  1 each  clear IF/ID, ID/EX, EX/MEM register to bubble
md_done  out  1  last EX cycle of a mul/div
proto_err  out  1  sticky: md_start seen while MD_BUSY
stall_count  out  16  saturating count of cycles with stall_if=1

Behaviour:
- States: RUN and MD_BUSY, plus a CNT_W-bit counter cnt. Outputs are combinational from state, cnt and inputs. No added latency: controls apply to the posedge that ends the current cycle.
- Reset (reset_n=0, async):
  - state=RUN, cnt=0, proto_err=0, stall_count=0.
  - While reset_n=0: all stall_*=0, flush_id=flush_ex=flush_mem=1, md_done=0.
- Priority, highest first:
  1. mem_wait=1:
     - stall_if/id/ex/mem=1, all flush=0.
     - cnt frozen, state held.
     - md_start and branch_taken are not acted on. EX is held, so upstream re-presents them after the wait.
  2. MD stall (RUN with md_start=1, or MD_BUSY with cnt>1):
     - stall_if/id/ex=1, flush_mem=1, stall_mem=0.
  3. branch_taken=1 (RUN, no md stall): flush_id=1, flush_ex=1, no stalls.
  4. Load-use: ex_load and ex_rd!=0 and ((id_use_rs and id_rs==ex_rd) or (id_use_rt and id_rt==ex_rd)).
     - stall_if=1, stall_id=1, flush_ex=1.
     - Exactly one bubble; the next cycle the load is in MEM and the hazard clears.
  5. Otherwise all outputs 0.
- Multi-cycle FSM (only when mem_wait=0):
  - RUN with md_start: cnt <= (md_div ? DIV_CYCLES : MUL_CYCLES) - 1; go to MD_BUSY.
  - MD_BUSY: cnt decrements each cycle.
  - MD_BUSY with cnt==1: no md stall, md_done=1, return to RUN.
  - Result: the instruction occupies EX for exactly N cycles, with N-1 stalled cycles.
  - md_start in MD_BUSY: ignored, sets proto_err (cleared only by reset).
  - branch_taken while MD stall is active: ignored; the mul/div in EX cannot be a branch.
  - In the md_done cycle, branch_taken/load-use rules apply normally.
- Simultaneous branch_taken and load-use: branch wins (ID instruction is flushed), so no stall.
- ex_rd==0 never causes a load-use stall.
- stall_count: +1 on each posedge with stall_if=1; saturates at 16'hFFFF; no wrap.

Test Plan:
- Reset mid-MD_BUSY (cnt=5): assert reset_n=0 -> immediately stalls=0, flushes=1; after release, state RUN, md_done never pulses, stall_count=0.
- Load-use: ex_load=1, ex_rd=7, id_rs=7, id_use_rs=1 for 1 cycle -> stall_if=stall_id=flush_ex=1 that cycle only; stall_count=1. Same with ex_rd=0 -> no outputs.
- Multiply: md_start=1, md_div=0, MUL_CYCLES=4 -> stall_if/id/ex=flush_mem=1 for cycles 0-2, md_done=1 in cycle 3, then RUN; divide gives 15 stall cycles, done in cycle 15.
- mem_wait=1 for 3 cycles inserted during divide at cnt=8 -> all four stalls=1, flush_mem=0, cnt stays 8; divide completes 3 cycles later than the uninterrupted case.
- branch_taken with simultaneous load-use hazard -> flush_id=flush_ex=1, stall_if=stall_id=0. branch_taken with mem_wait=1 -> only stalls; flushes occur the cycle mem_wait drops.
- md_start pulsed during MD_BUSY -> proto_err=1 and stays 1; timing unaffected. Hold stall for 70000 cycles -> stall_count=16'hFFFF.
